// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter (with sl_module)
// Description : Round-robin arbiter sharing one 32-bit left shifter between
//               two valid/ready requesters, feeding a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================

module sl_module (
    input  logic [31:0] data,
    input  logic        select1,
    input  logic        select2,
    input  logic        select3,
    input  logic        select4,
    input  logic        select5,
    output logic [31:0] result
);
    logic [4:0]  w_sel;
    logic [31:0] w_stage [0:5];

    assign w_sel      = {select5, select4, select3, select2, select1};
    assign w_stage[0] = data;

    // Barrel stages: stage k shifts by 2**k when its select bit is set.
    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_stage
            localparam int SH = 1 << k;
            assign w_stage[k+1] = w_sel[k] ? (w_stage[k] << SH) : w_stage[k];
        end
    endgenerate

    assign result = w_stage[5];
endmodule

module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic [CNTW-1:0]  ops_done
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_id_q,    out_id_d;
    logic             rr_q,        rr_d;
    logic [CNTW-1:0]  ops_done_q,  ops_done_d;

    logic             w_load;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_drain;
    logic [WIDTH-1:0] w_sh_in;
    logic [SHW-1:0]   w_sh_amt;
    logic [WIDTH-1:0] w_sh_out;

    assign w_load  = ~out_valid_q | out_ready;
    assign w_drain = out_valid_q & out_ready;

    // Reset gating keeps both readys low for the whole reset window.
    assign w_grant0 = w_load & ~reset & req0_valid & (~req1_valid | ~rr_q);
    assign w_grant1 = w_load & ~reset & req1_valid & (~req0_valid |  rr_q);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_sh_in  = w_grant1 ? req1_data : req0_data;
    assign w_sh_amt = w_grant1 ? req1_amt  : req0_amt;

    sl_module u_sl (
        .data    (w_sh_in),
        .select1 (w_sh_amt[0]),
        .select2 (w_sh_amt[1]),
        .select3 (w_sh_amt[2]),
        .select4 (w_sh_amt[3]),
        .select5 (w_sh_amt[4]),
        .result  (w_sh_out)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_d        = rr_q;
        ops_done_d  = ops_done_q + {{(CNTW-1){1'b0}}, w_drain};
        if (w_grant0 | w_grant1) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sh_out;
            out_id_d    = w_grant1;
            rr_d        = ~w_grant1;
        end else if (w_drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            rr_q        <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_q        <= rr_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign ops_done  = ops_done_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Directed self-checking bench for shift_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_data;
    logic [15:0] ops_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(32), .SHW(5), .CNTW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .ops_done   (ops_done)
    );

    task automatic do_reset;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req0_valid = 1'b1; req0_data = 32'h0000_1234; req0_amt = 5'd0; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_valid: got %0b want 1", out_valid);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async_valid: got %0b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 32'h0 || out_id !== 1'b0 || ops_done !== 16'd0) begin
            errors++; $display("FAIL reset_state: data %h id %0b ops %0d want 0 0 0", out_data, out_id, ops_done);
        end
        vectors++;
        if (req0_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %0b want 0", req0_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b0;
    endtask

    task automatic test_single_op;
        req0_valid = 1'b1; req0_data = 32'hFFFF_FFF8; req0_amt = 5'd1; out_ready = 1'b1;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %0b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFF0 || out_id !== 1'b0) begin
            errors++; $display("FAIL single_result: valid %0b data %h id %0b want 1 fffffff0 0",
                               out_valid, out_data, out_id);
        end
        @(negedge clk);
    endtask

    task automatic test_shift_sweep;
        logic [31:0] exp;
        out_ready = 1'b1;
        req1_valid = 1'b1; req1_data = 32'h0000_0001;
        for (int a = 0; a < 32; a++) begin
            req1_amt = a[4:0];
            @(negedge clk);
            exp = 32'h1 << a;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp || out_id !== 1'b1) begin
                errors++; $display("FAIL sweep_amt%0d: valid %0b data %h id %0b want 1 %h 1",
                                   a, out_valid, out_data, out_id, exp);
            end
        end
        req1_data = 32'hFFFF_FFF8; req1_amt = 5'd2;
        @(negedge clk);
        vectors++;
        if (out_data !== 32'hFFFF_FFE0) begin
            errors++; $display("FAIL sweep_neg: got %h want ffffffe0", out_data);
        end
        req1_data = 32'h8000_0001; req1_amt = 5'd31;
        @(negedge clk);
        vectors++;
        if (out_data !== 32'h8000_0000) begin
            errors++; $display("FAIL sweep_31: got %h want 80000000", out_data);
        end
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h0000_000A; req0_amt = 5'd0;
        req1_valid = 1'b1; req1_data = 32'h0000_000B; req1_amt = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (out_id !== i[0] || out_data !== (i[0] ? 32'hB : 32'hA)) begin
                errors++; $display("FAIL contend_rr0_%0d: id %0b data %h want %0b", i, out_id, out_data, i[0]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ops_done !== 16'd4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL contend_ops: ops %0d valid %0b want 4 0", ops_done, out_valid);
        end
        // A lone req0 op leaves priority with requester 1.
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (out_id !== ~i[0]) begin
                errors++; $display("FAIL contend_rr1_%0d: id %0b want %0b", i, out_id, ~i[0]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h0000_00A5; req0_amt = 5'd0;
        req1_valid = 1'b1; req1_data = 32'h0000_0123; req1_amt = 5'd4;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_data = 32'hDEAD_0000 + i;
            #1;
            vectors++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready_%0d: r0 %0b r1 %0b want 0 0", i, req0_ready, req1_ready);
            end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_00A5 || out_id !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: valid %0b data %h id %0b want 1 000000a5 0",
                                   i, out_valid, out_data, out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL bp_release_ready: r0 %0b r1 %0b want 0 1", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_1230 || out_id !== 1'b1) begin
            errors++; $display("FAIL bp_reload: valid %0b data %h id %0b want 1 00001230 1",
                               out_valid, out_data, out_id);
        end
        @(negedge clk);
    endtask

    task automatic test_idle_drain;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h0000_0003; req0_amt = 5'd3;
        @(negedge clk);
        req0_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0018) begin
            errors++; $display("FAIL drain_load: valid %0b data %h want 1 00000018", out_valid, out_data);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || ops_done !== 16'd1 || out_data !== 32'h0000_0018) begin
            errors++; $display("FAIL drain_empty: valid %0b ops %0d data %h want 0 1 00000018",
                               out_valid, ops_done, out_data);
        end
    endtask

    task automatic test_counter_wrap;
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 5'd0;
        repeat (65536) @(negedge clk);
        vectors++;
        if (ops_done !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max: got %0d want 65535", ops_done);
        end
        @(negedge clk);
        vectors++;
        if (ops_done !== 16'd0) begin
            errors++; $display("FAIL wrap_zero: got %0d want 0", ops_done);
        end
        req0_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        test_reset();
        test_single_op();
        test_shift_sweep();
        test_contention();
        test_backpressure();
        test_idle_drain();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one instance of the 32-bit left-shift datapath `sl_module` between two requesters.
- Both requester channels are valid/ready; grants are round-robin.
- The shifted result goes into a one-entry output register with its own valid/ready handshake.
- Sits between the ALU operand-issue logic and the result bus. It is the only block that drives the `sl_module` select inputs.

Parameters:
- WIDTH, 32, data width; only 32 is supported, matching `sl_module`.
- SHW, 5, shift-amount width; equals log2(WIDTH).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  WIDTH  requester 0 operand.
- req0_amt  input  SHW  requester 0 shift amount, 0..31.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_data  input  WIDTH  requester 1 operand.
- req1_amt  input  SHW  requester 1 shift amount, 0..31.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_id  output  1  requester that issued the result.
- ops_done  output  CNTW  count of results consumed (out_valid & out_ready).

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_id=0, ops_done=0.
  - Round-robin pointer rr=0, so requester 0 has priority.
  - While reset is high, req0_ready=req1_ready=0.
  - Reset mid-operation discards the held result. No partial state survives.
- Shifter hookup:
  - One `sl_module` instance.
  - Operand is the muxed data of the granted requester.
  - select1..select5 = amt[0]..amt[4]: shift weights 1, 2, 4, 8, 16.
  - Result = data << amt; vacated LSBs are zero-filled; bits shifted past bit 31 are discarded.
- Load enable: load = ~out_valid | out_ready. The output register is empty, or it is being drained this cycle.
- Grant (combinational, evaluated only when load=1):
  - Only one requester valid: it is granted.
  - Both valid: the requester equal to rr is granted.
  - Neither valid: no grant.
- Ready rules:
  - reqN_ready = load & grantN.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Accept (reqN_valid & reqN_ready) at edge N:
  - out_data <= shifter result, out_id <= N, out_valid <= 1.
  - rr <= ~N, so the requester just served loses priority.
  - rr does not change on cycles with no accept.
- Drain with no new accept (out_valid & out_ready and no grant): out_valid <= 0. out_data and out_id keep their last values.
- Simultaneous drain and accept: out_valid stays 1 and the register reloads. Sustained throughput is one operation per cycle.
- Backpressure: while out_valid & ~out_ready, out_data and out_id hold stable and both readys are 0.
- Latency: exactly 1 cycle from accept edge to out_valid=1 with the result.
- ops_done increments by 1 on each cycle with out_valid & out_ready. It wraps from 2^CNTW-1 to 0.
- amt=0 passes data through unchanged. amt=31 leaves only data[0], at bit 31.
- Requester inputs are sampled only on the accepting edge. Changing them while not ready has no effect.

Test Plan:
- Reset then single op:
  - Assert reset mid-stream; out_valid must drop immediately (asynchronously), ops_done=0.
  - After release, req0 data=32'hFFFFFFF8 amt=1 with out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFFFFF0, out_id=0.
- Shift sweep:
  - Using req1, data=32'h00000001, amt 0..31 -> out_data=1<<amt, out_id=1.
  - data=32'hFFFFFFF8 amt=2 -> 32'hFFFFFFE0.
  - data=32'h80000001 amt=31 -> 32'h80000000.
- Contention:
  - Both valid every cycle, out_ready=1 -> grants alternate 0,1,0,1.
  - ops_done=4 after four consumed results.
  - Repeat with rr=1 at start -> order 1,0,1,0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with both requesters valid -> out_data/out_id stable and both readys 0.
  - Raise out_ready -> the same cycle reloads the next requester's result; no cycle with out_valid=0.
- Idle drain: one op, then no valid, out_ready=1 -> out_valid falls the cycle after the drain and ops_done=1.
- Counter wrap: force 65536 consumed results (CNTW=16) -> ops_done returns to 0.
